// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM encodings, decimal
// multipliers for building clock-rate parameters, and gate-window sizing.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam int unsigned K_MULT = 1_000;
    localparam int unsigned M_MULT = 1_000_000;

    function automatic int unsigned gate_cyc(input int unsigned clk_hz,
                                             input int unsigned gate_hz);
        return clk_hz / gate_hz;
    endfunction

    // A one-cycle window still needs a 1-bit counter to stay legal.
    function automatic int unsigned gate_w(input int unsigned cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/freq_meter_sig_edge_sync.sv
// Two-flop synchronizer plus a delay flop; o_rise flags a rising edge of i_sig.
// Latency: edge visible 2 fpga_clk cycles after i_sig is sampled; free-running, no stall.
module sig_edge_sync
    import freq_meter_pkg::*;
(
    input  logic fpga_clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;

    always_comb begin
        sync1_d = i_sig;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
        end
    end

    assign o_rise = sync2_q & ~sync3_q;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous signal over back-to-back gate windows.
// Latency: o_valid one cycle after the last window cycle; no backpressure, results are pulsed.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100 * M_MULT,
    parameter int unsigned GATE_HZ = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             fpga_clk,
    input  logic             rst,
    input  logic             i_sig,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_valid,
    output logic             o_ovf
);

    localparam int unsigned        GATE_CYC  = gate_cyc(CLK_HZ, GATE_HZ);
    localparam int unsigned        GATE_W    = gate_w(GATE_CYC);
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    logic rise;

    sig_edge_sync u_sync (
        .fpga_clk (fpga_clk),
        .rst      (rst),
        .i_sig    (i_sig),
        .o_rise   (rise)
    );

    state_e             state_q, state_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [CNT_W-1:0]   edge_q, edge_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;
    logic               ovf_out_q, ovf_out_d;

    logic               edge_sat;
    logic [CNT_W-1:0]   edge_next;
    logic               ovf_next;

    // An edge arriving while already at the ceiling is a lost edge: flag it.
    always_comb begin
        edge_sat  = rise && (edge_q == CNT_MAX);
        edge_next = edge_q + CNT_W'(rise && !edge_sat);
        ovf_next  = ovf_q | edge_sat;
    end

    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        edge_d    = edge_q;
        ovf_d     = ovf_q;
        count_d   = count_q;
        ovf_out_d = ovf_out_q;
        valid_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gate_d = '0;
                edge_d = '0;
                ovf_d  = 1'b0;
                if (i_en) state_d = ST_ARM;
            end
            ST_ARM: begin
                gate_d  = '0;
                edge_d  = '0;
                ovf_d   = 1'b0;
                state_d = i_en ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (!i_en) begin
                    state_d = ST_IDLE;
                    gate_d  = '0;
                    edge_d  = '0;
                    ovf_d   = 1'b0;
                end else if (gate_q == GATE_LAST) begin
                    // Publish and restart in the same cycle so windows abut.
                    count_d   = edge_next;
                    ovf_out_d = ovf_next;
                    valid_d   = 1'b1;
                    gate_d    = '0;
                    edge_d    = '0;
                    ovf_d     = 1'b0;
                end else begin
                    gate_d = gate_q + GATE_W'(1);
                    edge_d = edge_next;
                    ovf_d  = ovf_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gate_d  = '0;
                edge_d  = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gate_q    <= '0;
            edge_q    <= '0;
            ovf_q     <= 1'b0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            edge_q    <= edge_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign o_count = count_q;
    assign o_valid = valid_q;
    assign o_ovf   = ovf_out_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: 100-cycle windows, 8-bit and 4-bit counters side by side.
module tb_freq_meter;

    localparam int unsigned CLK_HZ  = 1000;
    localparam int unsigned GATE_HZ = 10;

    logic       fpga_clk = 1'b0;
    logic       rst      = 1'b1;
    logic       i_en     = 1'b0;
    logic       man_sig  = 1'b0;
    logic       gen_sig  = 1'b0;
    int         period   = 0;
    logic       i_sig;

    logic [7:0] count8;
    logic       valid8, ovf8;
    logic [3:0] count4;
    logic       valid4, ovf4;

    int n_vec = 0;
    int n_err = 0;

    assign i_sig = (period > 0) ? gen_sig : man_sig;

    freq_meter #(.CLK_HZ(CLK_HZ), .GATE_HZ(GATE_HZ), .CNT_W(8)) u_dut8 (
        .fpga_clk (fpga_clk),
        .rst      (rst),
        .i_sig    (i_sig),
        .i_en     (i_en),
        .o_count  (count8),
        .o_valid  (valid8),
        .o_ovf    (ovf8)
    );

    freq_meter #(.CLK_HZ(CLK_HZ), .GATE_HZ(GATE_HZ), .CNT_W(4)) u_dut4 (
        .fpga_clk (fpga_clk),
        .rst      (rst),
        .i_sig    (i_sig),
        .i_en     (i_en),
        .o_count  (count4),
        .o_valid  (valid4),
        .o_ovf    (ovf4)
    );

    initial forever #5 fpga_clk = ~fpga_clk;

    // Toggle gen_sig every `period` cycles while period is non-zero.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge fpga_clk);
            #1;
            if (period > 0) begin
                if (ph >= period - 1) begin
                    gen_sig = ~gen_sig;
                    ph = 0;
                end else begin
                    ph++;
                end
            end else begin
                ph = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge fpga_clk);
            cyc++;
        end while (!valid8 && cyc < budget);
        chk("valid_seen", 32'(valid8), 32'd1);
    endtask

    initial begin
        int cyc;
        int nv;

        repeat (3) @(posedge fpga_clk);
        #1 rst = 1'b0;
        @(negedge fpga_clk);
        chk("rst_count8", 32'(count8), 32'd0);
        chk("rst_valid8", 32'(valid8), 32'd0);
        chk("rst_ovf8",   32'(ovf8),   32'd0);
        chk("rst_count4", 32'(count4), 32'd0);

        // Enable with toggle-every-5 (period 10): 10 edges per window.
        @(posedge fpga_clk);
        #1;
        period = 5;
        i_en   = 1'b1;
        @(negedge fpga_clk);
        wait_valid(300, cyc);
        chk("first_latency", 32'(cyc), 32'd102);
        for (int w = 0; w < 3; w++) begin
            wait_valid(300, cyc);
            chk("spacing", 32'(cyc), 32'd100);
            chk("cnt_p10", 32'(count8), 32'd10);
            chk("ovf_p10", 32'(ovf8), 32'd0);
        end

        // Drop enable at gate_cnt 60: no result, old count held.
        repeat (60) @(posedge fpga_clk);
        #1 i_en = 1'b0;
        nv = 0;
        repeat (250) begin
            @(negedge fpga_clk);
            if (valid8) nv++;
        end
        chk("abort_no_valid", 32'(nv), 32'd0);
        chk("abort_hold", 32'(count8), 32'd10);
        @(posedge fpga_clk);
        #1 i_en = 1'b1;
        @(negedge fpga_clk);
        wait_valid(300, cyc);
        chk("rearm_latency", 32'(cyc), 32'd102);
        chk("rearm_cnt", 32'(count8), 32'd10);

        // Toggle every cycle: 50 edges, saturates the 4-bit counter.
        period = 1;
        wait_valid(300, cyc);
        wait_valid(300, cyc);
        chk("cnt_p2", 32'(count8), 32'd50);
        chk("ovf_p2", 32'(ovf8), 32'd0);
        chk("valid4_p2", 32'(valid4), 32'd1);
        chk("cnt4_sat", 32'(count4), 32'd15);
        chk("ovf4_sat", 32'(ovf4), 32'd1);

        // Toggle every 10 cycles: 5 edges, overflow clears.
        period = 10;
        wait_valid(300, cyc);
        wait_valid(300, cyc);
        chk("cnt_p20", 32'(count8), 32'd5);
        chk("ovf_p20", 32'(ovf8), 32'd0);
        chk("cnt4_p20", 32'(count4), 32'd5);
        chk("ovf4_clr", 32'(ovf4), 32'd0);

        // Held low: zero edges.
        man_sig = 1'b0;
        period  = 0;
        wait_valid(300, cyc);
        wait_valid(300, cyc);
        chk("cnt_zero", 32'(count8), 32'd0);

        // Rise reaches the detector on gate_cnt 99 (two sync stages after gate 97).
        repeat (97) @(posedge fpga_clk);
        #1 man_sig = 1'b1;
        wait_valid(300, cyc);
        chk("edge99_this", 32'(count8), 32'd1);
        chk("edge99_lat", 32'(cyc), 32'd4);
        wait_valid(300, cyc);
        chk("edge99_next", 32'(count8), 32'd0);

        // Reset lands on gate_cnt 99 together with a detected edge.
        @(posedge fpga_clk);
        #1 man_sig = 1'b0;
        repeat (96) @(posedge fpga_clk);
        #1 man_sig = 1'b1;
        repeat (2) @(posedge fpga_clk);
        #1 rst = 1'b1;
        @(posedge fpga_clk);
        #1;
        rst     = 1'b0;
        man_sig = 1'b0;
        nv = 0;
        repeat (20) begin
            @(negedge fpga_clk);
            if (valid8) nv++;
        end
        chk("rst99_no_valid", 32'(nv), 32'd0);
        chk("rst99_count", 32'(count8), 32'd0);
        chk("rst99_ovf", 32'(ovf8), 32'd0);
        chk("rst99_count4", 32'(count4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
